// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the adder lab: state encodings (also decoded by the
// LED display driver) and default widths.
package adder_operand_loader_pkg;

  localparam int unsigned WidthDefault = 4;
  localparam int unsigned CntWDefault  = 8;

  // Encodings are visible on the LEDs, so they must stay fixed.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHaveA = 2'd1,
    StCalc  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // States in which a load starts a new operation by capturing operand A.
  function automatic logic accepts_new_a(state_e s);
    return (s == StIdle) || (s == StDone);
  endfunction

endpackage

// File: rtl/adder_operand_loader.sv
// Operand loader and result capture for the lab's external combinational adder.
// Two load pulses capture A then B; the following cycle registers the adder's
// {carry, sum} and updates the wrap-around operation and carry counters.
module adder_operand_loader
  import adder_operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     res_q, res_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;

  // State register; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over load, and load in StCalc is dropped.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (load) state_d = StHaveA;
        StHaveA:        if (load) state_d = StCalc;
        StCalc:         state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // Datapath next values, decoded from the current state and inputs.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    if (clear) begin
      // Soft clear abandons the operation but keeps the statistics.
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == StCalc) begin
      // Operands have been stable for a full cycle, so the adder has settled.
      res_d   = {carry_in, sum_in};
      valid_d = 1'b1;
      op_d    = op_q + CNT_W'(1);
      ovf_d   = ovf_q + {{(CNT_W-1){1'b0}}, carry_in};
    end else if (load) begin
      if (accepts_new_a(state_q)) begin
        // Old result stays on display until the next addition overwrites it.
        a_d     = din;
        b_d     = '0;
        valid_d = 1'b0;
      end else if (state_q == StHaveA) begin
        b_d = din;
      end
    end
  end

  // Datapath registers, including counters, all zeroed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
      ovf_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are direct register views.
  always_comb begin
    a_out        = a_q;
    b_out        = b_q;
    result       = res_q;
    result_valid = valid_q;
    busy         = (state_q == StCalc);
    state        = state_q;
    op_count     = op_q;
    ovf_count    = ovf_q;
  end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Bench for adder_operand_loader: directed vectors, an abstract model of the
// operation sequence checked every cycle, plus literal expectations.
module tb_adder_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] a_out, b_out, sum_in;
  logic       carry_in;
  logic [4:0] result;
  logic       result_valid, busy;
  logic [1:0] state;
  logic [7:0] op_count, ovf_count;
  logic [4:0] adder_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 have A, 2 calculating, 3 done.
  int         m_phase;
  logic [3:0] m_a, m_b;
  logic [4:0] m_res;
  logic       m_valid;
  int         m_ops, m_ovf;

  always #5 clk = ~clk;

  // The external combinational adder.
  assign adder_out = {1'b0, a_out} + {1'b0, b_out};
  assign sum_in    = adder_out[3:0];
  assign carry_in  = adder_out[4];

  adder_operand_loader #(.WIDTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .load         (load),
    .clear        (clear),
    .a_out        (a_out),
    .b_out        (b_out),
    .sum_in       (sum_in),
    .carry_in     (carry_in),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .state        (state),
    .op_count     (op_count),
    .ovf_count    (ovf_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_res = 0; m_valid = 0; m_ops = 0; m_ovf = 0;
    end else if (clear) begin
      m_phase = 0; m_a = 0; m_b = 0; m_res = 0; m_valid = 0;
    end else if (m_phase == 2) begin
      m_res   = {1'b0, m_a} + {1'b0, m_b};
      m_valid = 1'b1;
      m_ops   = (m_ops + 1) % 256;
      m_ovf   = (m_ovf + m_res[4]) % 256;
      m_phase = 3;
    end else if (load) begin
      if (m_phase == 1) begin
        m_b = din; m_phase = 2;
      end else begin
        m_a = din; m_b = 0; m_valid = 0; m_phase = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_phase));
    chk("busy", 32'(busy), 32'(m_phase == 2));
    chk("a_out", 32'(a_out), 32'(m_a));
    chk("b_out", 32'(b_out), 32'(m_b));
    chk("result", 32'(result), 32'(m_res));
    chk("result_valid", 32'(result_valid), 32'(m_valid));
    chk("op_count", 32'(op_count), 32'(m_ops));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic tick(input logic ld, input logic cl, input logic [3:0] d, input logic r);
    rst = r; load = ld; clear = cl; din = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    rst = 1'b0; load = 1'b0; clear = 1'b0; din = '0;
  endtask

  task automatic add(input logic [3:0] a, input logic [3:0] b);
    tick(1'b1, 1'b0, a, 1'b0);
    tick(1'b1, 1'b0, b, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    #2;
    tick(1'b0, 1'b0, 4'h0, 1'b1);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);

    // 3 + 4
    tick(1'b1, 1'b0, 4'h3, 1'b0);
    chk("first_a", 32'(a_out), 32'h3);
    chk("have_a_state", 32'(state), 32'd1);
    tick(1'b1, 1'b0, 4'h4, 1'b0);
    chk("second_b", 32'(b_out), 32'h4);
    chk("calc_busy", 32'(busy), 32'd1);
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    chk("sum_3_4", 32'(result), 32'h07);
    chk("valid_3_4", 32'(result_valid), 32'd1);
    chk("op_after_1", 32'(op_count), 32'd1);
    chk("ovf_after_1", 32'(ovf_count), 32'd0);

    // Carry cases
    add(4'hF, 4'h1);
    chk("sum_f_1", 32'(result), 32'h10);
    chk("ovf_after_f1", 32'(ovf_count), 32'd1);
    add(4'hF, 4'hF);
    chk("sum_f_f", 32'(result), 32'h1E);
    chk("ovf_after_ff", 32'(ovf_count), 32'd2);

    // Load during the calculation cycle is ignored
    tick(1'b1, 1'b0, 4'h2, 1'b0);
    tick(1'b1, 1'b0, 4'h5, 1'b0);
    tick(1'b1, 1'b0, 4'h9, 1'b0);
    chk("ignored_load_state", 32'(state), 32'd3);
    chk("ignored_load_ops", 32'(op_count), 32'd4);
    tick(1'b0, 1'b0, 4'h0, 1'b0);
    chk("still_done", 32'(state), 32'd3);
    chk("sum_2_5", 32'(result), 32'h07);

    // Clear together with load in the have-A state
    tick(1'b1, 1'b0, 4'h9, 1'b0);
    chk("a_is_9", 32'(a_out), 32'h9);
    tick(1'b1, 1'b1, 4'h6, 1'b0);
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_a", 32'(a_out), 32'h0);
    chk("clear_ops_kept", 32'(op_count), 32'd4);
    chk("clear_ovf_kept", 32'(ovf_count), 32'd2);
    tick(1'b1, 1'b0, 4'h6, 1'b0);
    chk("new_a_after_clear", 32'(a_out), 32'h6);

    // Clear during the calculation cycle: no capture, no count
    tick(1'b1, 1'b0, 4'hA, 1'b0);
    tick(1'b0, 1'b1, 4'h0, 1'b0);
    chk("clear_calc_ops", 32'(op_count), 32'd4);
    chk("clear_calc_result", 32'(result), 32'h00);

    // Drive the operation counter through its wrap
    for (int i = 0; i < 252; i++) begin
      add(4'(i), 4'(i * 7));
    end
    chk("op_wrap", 32'(op_count), 32'd0);

    // Reset during the calculation cycle
    tick(1'b1, 1'b0, 4'h8, 1'b0);
    tick(1'b1, 1'b0, 4'h8, 1'b0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    tick(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_calc_ops", 32'(op_count), 32'd0);
    chk("rst_calc_result", 32'(result), 32'h00);
    chk("rst_calc_a", 32'(a_out), 32'h0);
    tick(1'b0, 1'b0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
